// File: rtl/dataout_monitor.sv
// -----------------------------------------------------------------------------
// dataout_monitor
//
// Watches the system data-out bus and captures every new value into a small
// first-word-fall-through FIFO. A debug/host sink drains the FIFO over a
// valid/ready handshake. The monitor never back-pressures the processor: when
// the FIFO is full, new values are discarded and counted in a saturating drop
// counter.
//
// Ports:
//   DATAOUT_MONITOR_CLOCK_50          in   system clock (rising edge)
//   DATAOUT_MONITOR_ResetInLow_In     in   asynchronous active-low reset
//   DATAOUT_MONITOR_Data_InBus        in   monitored data-out bus
//   DATAOUT_MONITOR_CaptureEnable_In  in   1 = monitoring active
//   DATAOUT_MONITOR_Ready_In          in   sink accepts the head entry
//   DATAOUT_MONITOR_ClearDrop_In      in   synchronous clear of drop counter
//   DATAOUT_MONITOR_Data_OutBus       out  FIFO head value (0 when empty)
//   DATAOUT_MONITOR_Valid_Out         out  head entry valid
//   DATAOUT_MONITOR_Level_OutBus      out  number of stored entries
//   DATAOUT_MONITOR_Full_Out          out  level == depth
//   DATAOUT_MONITOR_Empty_Out         out  level == 0
//   DATAOUT_MONITOR_DropCount_OutBus  out  values dropped while full
//
// Optional feature, macro DATAOUT_MONITOR_TIMESTAMP_EN:
//   adds a free-running cycle counter; each entry stores the counter value of
//   its capture edge, presented on DATAOUT_MONITOR_Timestamp_OutBus with the
//   same FWFT timing as the data. The DATAWIDTH_TIMESTAMP parameter exists only
//   in that build.
//
// Handshake: the head entry is transferred on every rising edge where
// Valid_Out=1 and Ready_In=1. Valid_Out does not depend on Ready_In, and the
// head value is held stable while Valid_Out=1 and Ready_In=0.
// -----------------------------------------------------------------------------
module dataout_monitor #(
  parameter int DATAWIDTH_BUS       = 32,
  parameter int FIFO_DEPTH_LOG2     = 3,
  parameter int DATAWIDTH_DROPCOUNT = 8
`ifdef DATAOUT_MONITOR_TIMESTAMP_EN
  , parameter int DATAWIDTH_TIMESTAMP = 16
`endif
) (
  input  logic                         DATAOUT_MONITOR_CLOCK_50,
  input  logic                         DATAOUT_MONITOR_ResetInLow_In,
  input  logic [DATAWIDTH_BUS-1:0]     DATAOUT_MONITOR_Data_InBus,
  input  logic                         DATAOUT_MONITOR_CaptureEnable_In,
  input  logic                         DATAOUT_MONITOR_Ready_In,
  input  logic                         DATAOUT_MONITOR_ClearDrop_In,
  output logic [DATAWIDTH_BUS-1:0]     DATAOUT_MONITOR_Data_OutBus,
  output logic                         DATAOUT_MONITOR_Valid_Out,
  output logic [FIFO_DEPTH_LOG2:0]     DATAOUT_MONITOR_Level_OutBus,
  output logic                         DATAOUT_MONITOR_Full_Out,
  output logic                         DATAOUT_MONITOR_Empty_Out,
`ifdef DATAOUT_MONITOR_TIMESTAMP_EN
  output logic [DATAWIDTH_TIMESTAMP-1:0] DATAOUT_MONITOR_Timestamp_OutBus,
`endif
  output logic [DATAWIDTH_DROPCOUNT-1:0] DATAOUT_MONITOR_DropCount_OutBus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [DATAWIDTH_BUS-1:0]       last_q, last_d;
  logic                           primed_q, primed_d;
  logic [DATAWIDTH_DROPCOUNT-1:0] drop_q, drop_d;
  logic [DATAWIDTH_BUS-1:0]       mem_q [DEPTH];

  logic empty, full;
  logic cap_event, pop, push, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

  // Event qualification. An unprimed monitor captures whatever it samples
  // first, so a constant bus is still recorded once after enable.
  always_comb begin
    cap_event = DATAOUT_MONITOR_CaptureEnable_In &&
                (!primed_q || (DATAOUT_MONITOR_Data_InBus != last_q));
    pop       = !empty && DATAOUT_MONITOR_Ready_In;
    // A pop on the same edge frees the slot that the write reuses when full.
    push      = cap_event && (!full || pop);
    drop      = cap_event && full && !pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    primed_d = primed_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    // Last-value tracks dropped values too, so an unchanged bus is not
    // re-captured once space frees up.
    if (cap_event) last_d = DATAOUT_MONITOR_Data_InBus;

    if (!DATAOUT_MONITOR_CaptureEnable_In) primed_d = 1'b0;
    else if (cap_event)                    primed_d = 1'b1;

    if (DATAOUT_MONITOR_ClearDrop_In) begin
      drop_d = drop ? {{(DATAWIDTH_DROPCOUNT-1){1'b0}}, 1'b1} : '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge DATAOUT_MONITOR_CLOCK_50 or negedge DATAOUT_MONITOR_ResetInLow_In) begin
    if (!DATAOUT_MONITOR_ResetInLow_In) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      primed_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      primed_q <= primed_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge DATAOUT_MONITOR_CLOCK_50) begin
    if (push) mem_q[wr_ptr_q[PW-2:0]] <= DATAOUT_MONITOR_Data_InBus;
  end

  assign DATAOUT_MONITOR_Data_OutBus      = empty ? '0 : mem_q[rd_ptr_q[PW-2:0]];
  assign DATAOUT_MONITOR_Valid_Out        = !empty;
  assign DATAOUT_MONITOR_Empty_Out        = empty;
  assign DATAOUT_MONITOR_Full_Out         = full;
  assign DATAOUT_MONITOR_Level_OutBus     = wr_ptr_q - rd_ptr_q;
  assign DATAOUT_MONITOR_DropCount_OutBus = drop_q;

`ifdef DATAOUT_MONITOR_TIMESTAMP_EN
  logic [DATAWIDTH_TIMESTAMP-1:0] ts_q, ts_d;
  logic [DATAWIDTH_TIMESTAMP-1:0] ts_mem_q [DEPTH];

  // Free-running; wraps naturally at all-ones.
  always_comb begin
    ts_d = ts_q + 1'b1;
  end

  always_ff @(posedge DATAOUT_MONITOR_CLOCK_50 or negedge DATAOUT_MONITOR_ResetInLow_In) begin
    if (!DATAOUT_MONITOR_ResetInLow_In) ts_q <= '0;
    else                                ts_q <= ts_d;
  end

  // The stamp is the counter value seen at the capture edge.
  always_ff @(posedge DATAOUT_MONITOR_CLOCK_50) begin
    if (push) ts_mem_q[wr_ptr_q[PW-2:0]] <= ts_q;
  end

  assign DATAOUT_MONITOR_Timestamp_OutBus = empty ? '0 : ts_mem_q[rd_ptr_q[PW-2:0]];
`endif

endmodule
